// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter for the single write port of the 16-entry
//               key/data register file. The winning beat is registered into
//               one output stage that drives the write-select decoder. A
//               requester may lock the grant for multi-word sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [4*NREQ-1:0]  req_addr,
    input  logic [DW*NREQ-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               wr_stall,
    output logic               wr_en,
    output logic [3:0]         wr_addr,
    output logic [DW-1:0]      wr_data,
    output logic [PW-1:0]      gnt_id,
    output logic               locked
);

    typedef enum logic [0:0] {
        S_ARB    = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_owner;
    logic [PW-1:0]   r_rr_ptr;
    logic            r_wr_en;
    logic [3:0]      r_wr_addr;
    logic [DW-1:0]   r_wr_data;
    logic [PW-1:0]   r_gnt_id;

    logic            w_free;
    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [PW:0]     w_idx;
    logic [PW-1:0]   w_sel;
    logic            w_offer;
    logic            w_accept;
    logic            w_sel_lock;
    logic [3:0]      w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    // Pointer advance with wrap at NREQ (NREQ need not be a power of two).
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        if (p == PW'(NREQ - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // The stage can take a new beat when it is empty or its write commits now.
    assign w_free = !r_wr_en || !wr_stall;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NREQ)) begin
                w_idx = w_idx - (PW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_idx[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    // While locked only the owner is offered the port, even when idle.
    always_comb begin
        w_sel      = (r_state == S_LOCKED) ? r_owner : w_winner;
        w_offer    = w_free && ((r_state == S_LOCKED) || w_found);
        req_ready  = w_offer ? (NREQ'(1) << w_sel) : '0;
        w_accept   = w_offer && req_valid[w_sel];
        w_sel_lock = req_lock[w_sel];
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == PW'(i)) begin
                w_sel_addr = req_addr[4*i +: 4];
                w_sel_data = req_data[DW*i +: DW];
            end
        end
    end

    // Arbitration state, round-robin pointer and the registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_ARB;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_gnt_id  <= '0;
        end else if (w_free) begin
            // An idle cycle clears the strobe but keeps the last address/data.
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
                r_gnt_id  <= w_sel;
                case (r_state)
                    S_ARB: begin
                        if (w_sel_lock) begin
                            r_state <= S_LOCKED;
                            r_owner <= w_sel;
                        end else begin
                            r_rr_ptr <= f_next(w_sel);
                        end
                    end
                    S_LOCKED: begin
                        if (!w_sel_lock) begin
                            r_state  <= S_ARB;
                            r_rr_ptr <= f_next(r_owner);
                        end
                    end
                    default: r_state <= S_ARB;
                endcase
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign gnt_id  = r_gnt_id;
    assign locked  = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 16-entry key/data register file among NREQ requesters (key loader, round datapath, delta accumulator, host bus).
- Registers the winning write into one output stage.
- WR_ADDR and WR_EN drive the register file's 4-to-16 write-select decoder directly (WR_ADDR[3..0] to IN3..IN0, WR_EN to EN).
- Supports locked multi-word sequences, e.g. writing a 128-bit key to four consecutive registers.

Parameters:
- NREQ, 4, number of requesters (2..8); PW = clog2(NREQ).
- DW, 32, register data width.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  NREQ  per-requester write request.
- REQ_LOCK  in  NREQ  requester asks to keep the grant after this beat.
- REQ_ADDR  in  4*NREQ  register index; requester i uses bits [4i+3:4i].
- REQ_DATA  in  DW*NREQ  write data; requester i uses bits [DW*i+DW-1:DW*i].
- REQ_READY  out  NREQ  one-hot accept; beat i transfers when REQ_VALID[i] & REQ_READY[i].
- WR_STALL  in  1  register file cannot take a write this cycle.
- WR_EN  out  1  registered write strobe to the decoder EN.
- WR_ADDR  out  4  registered register index.
- WR_DATA  out  DW  registered write data.
- GNT_ID  out  PW  index of the requester whose beat is in the output stage.
- LOCKED  out  1  high while the arbiter is in LOCKED.

Behaviour:
- Reset (async assert, sync release): WR_EN=0, WR_ADDR=0, WR_DATA=0, GNT_ID=0, LOCKED=0, rr_ptr=0, state=ARB.
- Output stage is free when !WR_EN | !WR_STALL. REQ_READY is all-zero whenever the stage is not free.
- WR_STALL with WR_EN=1: WR_EN, WR_ADDR, WR_DATA and GNT_ID hold unchanged.
- Write commit: a write commits in each cycle where WR_EN=1 and WR_STALL=0.
- State ARB:
  - Winner = first i with REQ_VALID[i]=1, scanning from rr_ptr upward modulo NREQ.
  - REQ_READY = onehot(winner), combinational, same cycle.
  - On accept: the output stage loads addr/data, WR_EN=1 and GNT_ID=winner on the next edge, so latency is 1 cycle from accept to WR_EN.
  - If REQ_LOCK[winner]=1: go to LOCKED with owner=winner; rr_ptr unchanged.
  - Otherwise: rr_ptr = (winner+1) mod NREQ.
- State LOCKED:
  - Only the owner is eligible; REQ_READY = onehot(owner) when the stage is free, even if REQ_VALID[owner]=0. Other requesters starve.
  - An accepted beat with REQ_LOCK[owner]=0 ends the lock: go to ARB, rr_ptr = (owner+1) mod NREQ.
  - REQ_VALID[owner] low for any number of cycles: stay LOCKED.
- No accept in a cycle where the stage is free: WR_EN goes to 0 on the next edge. WR_ADDR, WR_DATA and GNT_ID keep their last values.
- Back-to-back: with the stage continuously free, one beat per cycle. A committing write and a new accept happen in the same cycle, so WR_EN stays 1.
- Duplicate addresses from different requesters are not merged. Both writes commit in grant order; the last granted wins.
- Reset mid-transfer: the pending write is dropped (WR_EN=0 immediately), any lock is released and rr_ptr returns to 0.

Test Plan:
- Reset: RST_N=0 asserted asynchronously mid-cycle, with WR_EN=1 -> WR_EN=0 before the next edge. After release: LOCKED=0, and with REQ_VALID=4'b1111 the first grant is GNT_ID=0.
- Round-robin: REQ_VALID=4'b1111 held, no stall, REQ_ADDR[i]=i+4 -> grants 0,1,2,3,0. WR_ADDR sequence 4,5,6,7,4 with WR_EN=1 every cycle from cycle 2.
- Stall: WR_STALL=1 for 3 cycles while WR_EN=1, WR_ADDR=9, WR_DATA=32'hDEADBEEF -> outputs frozen and REQ_READY=0 throughout. After WR_STALL drops, the write commits once and the next grant follows 1 cycle later.
- Lock: requester 2 sends 4 beats to addr 0..3 with REQ_LOCK=1,1,1,0 while requesters 0, 1 and 3 are valid -> 4 consecutive grants to 2 with LOCKED=1 for beats 1–3. The next grant is 3.
- Lock gap: during LOCKED, the owner deasserts REQ_VALID for 5 cycles while others are valid -> no grants to others, WR_EN=0 and LOCKED stays 1. The owner resumes with REQ_LOCK=0 -> one write, then arbitration continues from owner+1.
- Same-address collision: requesters 0 and 1 both write addr 15, data 32'h11111111 and 32'h22222222 -> two commits in order 0 then 1. The register-file model ends with 32'h22222222.
